// File: rtl/mem_sched_pkg.sv
// Shared encodings and default parameters for the instruction/data RAM scheduler.
package mem_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

  localparam int RD_LAT_DEF   = 1;
  localparam int DATA_MAX_DEF = 3;

endpackage

// File: rtl/mem_sched_pick.sv
// Fetch/data priority pick with a starvation guard: D normally wins, but
// after DATA_MAX consecutive D grants while IF waits, IF gets the port.
module mem_sched_pick
  import mem_sched_pkg::*;
#(
  parameter int DATA_MAX = DATA_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic window_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  localparam logic [3:0] SMAX = 4'(DATA_MAX);

  logic [3:0] streak_q, streak_d;
  logic       d_wins;

  // Combinational winner selection, only effective inside the grant window
  always_comb begin
    d_wins   = d_req_i && !(if_req_i && (streak_q == SMAX));
    d_gnt_o  = window_i && d_wins;
    if_gnt_o = window_i && !d_wins && if_req_i;
  end

  // Streak counts D grants taken while IF is waiting; any IF grant or idle IF clears it
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt_o)
      streak_d = '0;
    else if (d_gnt_o && (streak_q != SMAX))
      streak_d = streak_q + 4'd1;
  end

  // Streak register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) streak_q <= '0;
    else       streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_sched.sv
// Single-port RAM scheduler between fetch (IF) and load/store (D).
// Reads wait a fixed RD_LAT cycles; the next grant may overlap the return cycle.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int DATA_MAX = DATA_MAX_DEF,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAST = 3'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  src_e       src_q, src_d;

  logic window, ret_cyc, rd_gnt;

  // Grant window: idle, or the data-return cycle of the outstanding read.
  // Reset closes it so no grant leaks out while the core is held.
  always_comb begin
    ret_cyc = (state_q == WAIT) && (cnt_q == LAST);
    window  = !cpu_rst && ((state_q == IDLE) || ret_cyc);
  end

  mem_sched_pick #(.DATA_MAX(DATA_MAX)) u_pick (
    .clk_i    (cpu_clk),
    .rst_i    (cpu_rst),
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .window_i (window),
    .if_gnt_o (if_gnt),
    .d_gnt_o  (d_gnt)
  );

  // RAM port drive and read-data return to the owner
  always_comb begin
    rd_gnt    = if_gnt || (d_gnt && !d_we);
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    mem_wdata = (d_gnt && d_we) ? d_wdata : '0;
    if_rvalid = ret_cyc && (src_q == SRC_IF);
    d_rvalid  = ret_cyc && (src_q == SRC_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
    busy      = (state_q == WAIT);
  end

  // Next state: a read grant (re)starts the latency count; writes finish in place
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    if (state_q == WAIT) begin
      if (cnt_q == LAST) state_d = IDLE;
      else               cnt_d   = cnt_q + 3'd1;
    end
    if (rd_gnt) begin
      state_d = WAIT;
      cnt_d   = '0;
      src_d   = if_gnt ? SRC_IF : SRC_D;
    end
  end

  // State registers; reset drops any outstanding read
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= SRC_IF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: two instances (RD_LAT=1 and RD_LAT=3) each with a
// simple latency-accurate RAM, checked every cycle against a transaction model.
module tb_mem_sched;

  localparam int DM = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic        if_gnt   [2];
  logic        if_rvalid[2];
  logic [31:0] if_rdata [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic        d_gnt    [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata  [2];
  logic        mem_en   [2];
  logic        mem_we   [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        busy     [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_f(logic [31:0] a);
    return (a == 32'h40) ? 32'h0010_0093 : (a ^ 32'hDEAD_0000);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] pipe [8];

    mem_sched #(.RD_LAT(L), .DATA_MAX(DM), .AW(32), .DW(32)) u_dut (
      .cpu_clk(clk), .cpu_rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // RAM: read address of cycle T shows its data in cycle T+L
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem_addr[g] : 32'h0;
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = ram_f(pipe[L-1]);
  end

  // Transaction model state
  int          mcyc = 0;
  int          lat [2] = '{1, 3};
  bit          ov  [2] = '{0, 0};
  int          ret [2] = '{0, 0};
  bit          own [2] = '{0, 0};
  logic [31:0] ra  [2] = '{32'h0, 32'h0};
  int          stk [2] = '{0, 0};

  task automatic cmp(string nm, int i, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d cyc%0d got=%h exp=%h", nm, i, mcyc, got, exp);
    end
  endtask

  // Compare both instances against the model, then advance the model one cycle
  task automatic check();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit win, rv, dw, ig, dg;
      logic [31:0] ea, ew, erd;
      win = 0; rv = 0; ig = 0; dg = 0; ea = 0; ew = 0; erd = 0;
      if (!rst) begin
        win = !ov[i] || (mcyc == ret[i]);
        rv  = ov[i] && (mcyc == ret[i]);
        dw  = d_req[i] && !(if_req[i] && stk[i] == DM);
        dg  = win && dw;
        ig  = win && !dw && if_req[i];
        ea  = dg ? d_addr[i] : (ig ? if_addr[i] : 32'h0);
        ew  = (dg && d_we[i]) ? d_wdata[i] : 32'h0;
        erd = rv ? ram_f(ra[i]) : 32'h0;
      end
      cmp("if_gnt",    i, if_gnt[i],    ig);
      cmp("d_gnt",     i, d_gnt[i],     dg);
      cmp("mem_en",    i, mem_en[i],    ig | dg);
      cmp("mem_we",    i, mem_we[i],    dg & d_we[i]);
      cmp("mem_addr",  i, mem_addr[i],  ea);
      cmp("mem_wdata", i, mem_wdata[i], ew);
      cmp("busy",      i, busy[i],      !rst && ov[i]);
      cmp("if_rvalid", i, if_rvalid[i], rv && !own[i]);
      cmp("d_rvalid",  i, d_rvalid[i],  rv && own[i]);
      cmp("if_rdata",  i, if_rdata[i],  !own[i] ? erd : 32'h0);
      cmp("d_rdata",   i, d_rdata[i],   own[i] ? erd : 32'h0);
      if (rst) begin
        ov[i] = 0; stk[i] = 0;
      end else begin
        if (rv) ov[i] = 0;
        if (ig || !if_req[i]) stk[i] = 0;
        else if (dg && stk[i] < DM) stk[i]++;
        if (ig || (dg && !d_we[i])) begin
          ov[i] = 1; ret[i] = mcyc + lat[i]; own[i] = dg; ra[i] = ea;
        end
      end
    end
    mcyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int i, bit ir, logic [31:0] ia, bit dr, bit we,
                     logic [31:0] da, logic [31:0] wd);
    if_req[i] = ir; if_addr[i] = ia;
    d_req[i] = dr; d_we[i] = we; d_addr[i] = da; d_wdata[i] = wd;
  endtask

  task automatic idle(int i);
    drv(i, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    // Reset held with both requesters active: nothing may be granted
    for (int i = 0; i < 2; i++) drv(i, 1, 32'h40, 1, 0, 32'h80, 32'h0);
    for (int c = 0; c < 3; c++) begin
      check();
      cmp("rst_outs", 0, {29'h0, if_gnt[0], d_gnt[0], mem_en[0]}, 32'h0);
      tick();
    end

    // Release: IF fetch granted in the first cycle, data one cycle later (L=1)
    rst = 1'b0;
    for (int i = 0; i < 2; i++) drv(i, 1, 32'h40, 0, 0, 32'h0, 32'h0);
    check();
    cmp("lit_if_gnt", 0, if_gnt[0], 1);
    cmp("lit_addr40", 0, mem_addr[0], 32'h40);
    cmp("lit_we0",    0, mem_we[0], 0);
    tick();
    idle(0); idle(1);
    check();
    cmp("lit_if_rv",  0, if_rvalid[0], 1);
    cmp("lit_if_rd",  0, if_rdata[0], 32'h0010_0093);
    cmp("lit_d_rv0",  0, d_rvalid[0], 0);
    tick();
    for (int c = 0; c < 3; c++) begin check(); tick(); end

    // Back-to-back D writes, one per cycle, never busy
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) drv(i, 0, 32'h0, 1, 1, 32'h100 + 32'(4*k), 32'hA000 + 32'(k));
      check();
      cmp("lit_wr_gnt",  0, d_gnt[0], 1);
      cmp("lit_wr_we",   0, mem_we[0], 1);
      cmp("lit_wr_busy", 0, busy[0], 0);
      cmp("lit_wr_addr", 0, mem_addr[0], 32'h100 + 32'(4*k));
      tick();
    end
    idle(0); idle(1);
    check(); tick();

    // Fairness: both requesting, D writes; expect D,D,D,IF repeating (L=1)
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) drv(i, 1, 32'h200, 1, 1, 32'h400, 32'h55);
      check();
      cmp("lit_fair_d",  0, d_gnt[0],  (k % 4) != 3);
      cmp("lit_fair_if", 0, if_gnt[0], (k % 4) == 3);
      tick();
    end
    idle(0); idle(1);
    for (int c = 0; c < 4; c++) begin check(); tick(); end

    // Overlap (L=3): D read at T, IF pending; d_rvalid and if_gnt together at T+3
    drv(1, 1, 32'h44, 1, 0, 32'h300, 32'h0);
    check();
    cmp("lit_ov_dgnt", 1, d_gnt[1], 1);
    tick();
    drv(1, 1, 32'h44, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      check();
      cmp("lit_ov_nogrant", 1, if_gnt[1], 0);
      tick();
    end
    check();
    cmp("lit_ov_drv",  1, d_rvalid[1], 1);
    cmp("lit_ov_drd",  1, d_rdata[1], 32'hDEAD_0300);
    cmp("lit_ov_ifg",  1, if_gnt[1], 1);
    tick();
    idle(1);
    for (int c = 0; c < 2; c++) begin check(); tick(); end
    check();
    cmp("lit_ov_ifrv", 1, if_rvalid[1], 1);
    cmp("lit_ov_ifrd", 1, if_rdata[1], 32'hDEAD_0044);
    tick();
    for (int c = 0; c < 2; c++) begin check(); tick(); end

    // Reset at T+1 of a D read (L=3): the read is dropped
    drv(1, 0, 32'h0, 1, 0, 32'h320, 32'h0);
    check();
    cmp("lit_rr_dgnt", 1, d_gnt[1], 1);
    tick();
    idle(1);
    rst = 1'b1;
    check();
    cmp("lit_rr_norv", 1, d_rvalid[1], 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check();
      cmp("lit_rr_norv", 1, d_rvalid[1], 0);
      tick();
    end
    drv(1, 0, 32'h0, 1, 0, 32'h330, 32'h0);
    check();
    cmp("lit_rr_regnt", 1, d_gnt[1], 1);
    tick();
    idle(1);
    for (int c = 0; c < 2; c++) begin check(); tick(); end
    check();
    cmp("lit_rr_rv",  1, d_rvalid[1], 1);
    cmp("lit_rr_rd",  1, d_rdata[1], 32'hDEAD_0330);
    tick();
    check();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
Name: mem_sched

Overview:
- Shares the single-port instruction/data RAM between the fetch stage (IF) and the load/store path (D) of the multi-cycle miniRV core.
- Arbitrates requests and drives the RAM port.
- Counts fixed read latency and returns read data to the requester that issued the read.
- Sits between the core's fetch/LSU logic and the RAM; the controller stalls on missing grant or rvalid.

Parameters:
- RD_LAT, 1: RAM read latency in cycles, legal range 1..7.
- DATA_MAX, 3: maximum consecutive D grants while IF is waiting; legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- cpu_clk  in  1  clock, rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid this cycle.
- if_rdata  out  DW  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid this cycle.
- d_rdata  out  DW  load data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after the mem_en read cycle.
- busy  out  1  read outstanding.

Behaviour:
- Registered state: FSM state (IDLE, WAIT), latency counter cnt (3 bits), owner src (IF/D), streak counter (4 bits).
- Reset values: state=IDLE, cnt=0, src=IF, streak=0.
- Outputs at reset: all gnt, rvalid, mem_en, mem_we and busy are 0; mem_addr, mem_wdata and rdata are 0.
- Grant window: open when state==IDLE, or state==WAIT and cnt==RD_LAT-1.
- Grant is combinational within the window; at most one grant per cycle.
- Priority:
  - D wins when d_req=1 and NOT (if_req=1 and streak==DATA_MAX).
  - Otherwise IF wins if if_req=1.
- Streak rules:
  - Increments on a D grant while if_req=1, saturating at DATA_MAX.
  - Clears on any IF grant.
  - Clears when if_req=0.
- Grant cycle T:
  - mem_en=1; mem_addr = winner's address.
  - Write: mem_we=d_we, mem_wdata=d_wdata.
- D write:
  - Completes in cycle T; no rvalid.
  - Next state is IDLE, so back-to-back writes run one per cycle.
- Read (IF or D):
  - Next state is WAIT; cnt=0; src=winner.
  - busy=1 from T+1 through T+RD_LAT.
- WAIT:
  - cnt increments each cycle.
  - In cycle T+RD_LAT (cnt==RD_LAT-1): rvalid of src =1, rdata = mem_rdata (combinational pass-through).
  - A new grant may issue in the same cycle, so reads run one per RD_LAT cycles.
  - Leaving WAIT: a new read grant returns to WAIT with cnt=0; otherwise IDLE.
- rdata of the non-owner, and of either requester when rvalid=0, is held at 0.
- Requester contract: req, addr, we and wdata stay stable until gnt; req may drop the cycle after gnt.
- Dropping req before gnt withdraws the request; no side effect.
- Simultaneous rvalid of src and gnt of the other requester is legal and required for throughput.
- Reset mid-read:
  - Outstanding read is discarded; no rvalid after reset release.
  - FSM returns to IDLE asynchronously.
- mem_en=0 whenever no grant is issued. mem_addr/mem_wdata are don't-care then, but are driven 0.

Decomposition:
- Package mem_sched_pkg holds:
  - state encoding (IDLE=1'b0, WAIT=1'b1);
  - source encoding (SRC_IF=1'b0, SRC_D=1'b1);
  - default RD_LAT and DATA_MAX constants.
- One sub-module, mem_sched_pick: combinational priority plus streak counter.
  - Inputs: if_req, d_req, window.
  - Outputs: if_gnt, d_gnt.
- Top level holds FSM, latency counter and muxes.

Test Plan:
- Reset: hold cpu_rst=1 with if_req=d_req=1 -> all gnt/rvalid/mem_en=0.
- Release reset: with if_req=1 only -> if_gnt in the first cycle.
- IF read, RD_LAT=1:
  - Stimulus: if_req=1, if_addr=0x0000_0040, mem_rdata=0x0010_0093 one cycle later.
  - Required: if_gnt cycle T with mem_addr=0x40, mem_we=0; if_rvalid=1 and if_rdata=0x0010_0093 at T+1; d_rvalid=0.
- Back-to-back D writes:
  - Stimulus: d_req=d_we=1 for 3 cycles, addr 0x100/0x104/0x108.
  - Required: d_gnt=1 and mem_we=1 each cycle, busy=0 throughout.
- Fairness, DATA_MAX=3:
  - Stimulus: if_req=d_req=1 continuously, d_we=1.
  - Required: grant sequence D,D,D,IF,D,D,D,IF...
- Overlap, RD_LAT=3:
  - Stimulus: D read at T, IF pending.
  - Required: d_rvalid at T+3 and if_gnt at T+3 in the same cycle; if_rvalid at T+6.
- Reset at T+1 of a D read with RD_LAT=3 -> no d_rvalid in cycles T+1..T+6; first post-reset grant accepted normally.
